// File: rtl/pe_merge.sv
// Interleaves ACC_PER_FRAME accumulator words and one psum word per frame into
// a single PE input stream, with a 2-entry output buffer for backpressure.
module pe_merge #(
    parameter int DWIDTH        = 8,
    parameter int ACC_PER_FRAME = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DWIDTH-1:0]                      acc_in_data,
    input  logic                                   acc_in_valid,
    output logic                                   acc_in_ready,
    input  logic [DWIDTH-1:0]                      pkt_in_data,
    input  logic                                   pkt_in_valid,
    output logic                                   pkt_in_ready,
    output logic [DWIDTH-1:0]                      out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last,
    output logic [CNT_WIDTH-1:0]                   frame_count,
    output logic [$clog2(ACC_PER_FRAME+1)-1:0]     slot
);

    localparam int SW = $clog2(ACC_PER_FRAME + 1);
    localparam logic [SW-1:0] PKT_SLOT = SW'(ACC_PER_FRAME);

    logic [SW-1:0]        slot_r;
    logic [1:0]           count_r;
    logic [DWIDTH:0]      head_r;
    logic [DWIDTH:0]      tail_r;
    logic                 valid_r;
    logic [CNT_WIDTH-1:0] frame_count_r;

    logic            in_pkt_s;
    logic            space_s;
    logic            push_s;
    logic            pop_s;
    logic [DWIDTH:0] push_word_s;
    logic [1:0]      count_nxt_s;
    logic [DWIDTH:0] head_nxt_s;
    logic [DWIDTH:0] tail_nxt_s;

    // Readiness depends only on registered state and rst, never on out_ready.
    assign in_pkt_s     = (slot_r == PKT_SLOT);
    assign space_s      = (count_r != 2'd2) && !rst;
    assign acc_in_ready = space_s && !in_pkt_s;
    assign pkt_in_ready = space_s && in_pkt_s;
    assign pop_s        = valid_r && out_ready;

    // Select the input owned by the current slot and tag psum words as last.
    always_comb begin
        push_s      = 1'b0;
        push_word_s = '0;
        if (in_pkt_s) begin
            push_s      = pkt_in_valid && pkt_in_ready;
            push_word_s = {1'b1, pkt_in_data};
        end else begin
            push_s      = acc_in_valid && acc_in_ready;
            push_word_s = {1'b0, acc_in_data};
        end
    end

    // Next state of the 2-entry buffer; head is always the oldest word.
    always_comb begin
        count_nxt_s = count_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        case ({push_s, pop_s})
            2'b10: begin
                if (count_r == 2'd0) begin
                    head_nxt_s = push_word_s;
                end else begin
                    tail_nxt_s = push_word_s;
                end
                count_nxt_s = count_r + 2'd1;
            end
            2'b01: begin
                head_nxt_s  = tail_r;
                count_nxt_s = count_r - 2'd1;
            end
            // Push with pop only happens at count 1: the new word becomes head.
            2'b11: begin
                head_nxt_s = push_word_s;
            end
            default: begin
                count_nxt_s = count_r;
            end
        endcase
    end

    // Slot sequencing, buffer storage and frame counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r        <= '0;
            count_r       <= 2'd0;
            head_r        <= '0;
            tail_r        <= '0;
            valid_r       <= 1'b0;
            frame_count_r <= '0;
        end else begin
            count_r <= count_nxt_s;
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            valid_r <= (count_nxt_s != 2'd0);
            if (push_s) begin
                if (in_pkt_s) begin
                    slot_r        <= '0;
                    frame_count_r <= frame_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    slot_r        <= slot_r + {{(SW-1){1'b0}}, 1'b1};
                    frame_count_r <= frame_count_r;
                end
            end else begin
                slot_r        <= slot_r;
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign out_data    = head_r[DWIDTH-1:0];
    assign out_last    = head_r[DWIDTH];
    assign out_valid   = valid_r;
    assign frame_count = frame_count_r;
    assign slot        = slot_r;

endmodule

// File: tb/tb_pe_merge.sv
// Directed bench for pe_merge (ACC_PER_FRAME=2, CNT_WIDTH=2 so wrap is reachable).
module tb_pe_merge;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] acc_in_data;
    logic       acc_in_valid;
    logic       acc_in_ready;
    logic [7:0] pkt_in_data;
    logic       pkt_in_valid;
    logic       pkt_in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [1:0] frame_count;
    logic [1:0] slot;

    int n_checks = 0;
    int n_fail   = 0;

    pe_merge #(.DWIDTH(8), .ACC_PER_FRAME(2), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .acc_in_data(acc_in_data), .acc_in_valid(acc_in_valid), .acc_in_ready(acc_in_ready),
        .pkt_in_data(pkt_in_data), .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_count(frame_count), .slot(slot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic l);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_last"},  32'(out_last),  32'(l));
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        acc_in_valid = 1'b1; acc_in_data = 8'h5A;
        pkt_in_valid = 1'b1; pkt_in_data = 8'hA5;
        // Reset held two edges with both inputs valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_acc_rdy", 32'(acc_in_ready), 32'd0);
        chk("rst_pkt_rdy", 32'(pkt_in_ready), 32'd0);
        chk_out("rst_out", 1'b0, 8'h00, 1'b0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        chk("rst_slot", 32'(slot), 32'd0);
        rst = 1'b0; acc_in_valid = 1'b0; pkt_in_valid = 1'b0;
        #1;
        chk("rel_acc_rdy", 32'(acc_in_ready), 32'd1);
        chk("rel_pkt_rdy", 32'(pkt_in_ready), 32'd0);

        // Streaming: 11,22,A0,33,44,B0
        acc_in_valid = 1'b1; acc_in_data = 8'h11;
        pkt_in_valid = 1'b1; pkt_in_data = 8'hA0;
        @(negedge clk);
        chk_out("s1", 1'b1, 8'h11, 1'b0);
        chk("s1_slot", 32'(slot), 32'd1);
        acc_in_data = 8'h22;
        @(negedge clk);
        chk_out("s2", 1'b1, 8'h22, 1'b0);
        chk("s2_pkt_rdy", 32'(pkt_in_ready), 32'd1);
        chk("s2_acc_rdy", 32'(acc_in_ready), 32'd0);
        acc_in_data = 8'h33;
        @(negedge clk);
        chk_out("s3", 1'b1, 8'hA0, 1'b1);
        chk("s3_fc", 32'(frame_count), 32'd1);
        chk("s3_slot", 32'(slot), 32'd0);
        pkt_in_data = 8'hB0;
        @(negedge clk);
        chk_out("s4", 1'b1, 8'h33, 1'b0);
        acc_in_data = 8'h44;
        @(negedge clk);
        chk_out("s5", 1'b1, 8'h44, 1'b0);
        @(negedge clk);
        chk_out("s6", 1'b1, 8'hB0, 1'b1);
        chk("s6_fc", 32'(frame_count), 32'd2);
        acc_in_valid = 1'b0; pkt_in_valid = 1'b0;
        @(negedge clk);
        chk("s7_valid", 32'(out_valid), 32'd0);

        // Ordering hold: psum offered early, acc words 3 cycles late
        pkt_in_valid = 1'b1; pkt_in_data = 8'hC0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("oh_pkt_rdy", 32'(pkt_in_ready), 32'd0);
            chk("oh_valid", 32'(out_valid), 32'd0);
            chk("oh_slot", 32'(slot), 32'd0);
        end
        acc_in_valid = 1'b1; acc_in_data = 8'h55;
        @(negedge clk);
        chk_out("oh1", 1'b1, 8'h55, 1'b0);
        acc_in_data = 8'h66;
        @(negedge clk);
        chk_out("oh2", 1'b1, 8'h66, 1'b0);
        acc_in_valid = 1'b0;
        @(negedge clk);
        chk_out("oh3", 1'b1, 8'hC0, 1'b1);
        chk("oh3_fc", 32'(frame_count), 32'd3);
        pkt_in_valid = 1'b0;
        @(negedge clk);
        chk("oh4_valid", 32'(out_valid), 32'd0);

        // Backpressure: out_ready low 5 cycles
        out_ready = 1'b0;
        acc_in_valid = 1'b1; acc_in_data = 8'h77;
        pkt_in_valid = 1'b1; pkt_in_data = 8'hD0;
        @(negedge clk);
        chk_out("bp1", 1'b1, 8'h77, 1'b0);
        chk("bp1_acc_rdy", 32'(acc_in_ready), 32'd1);
        acc_in_data = 8'h88;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_out("bp_hold", 1'b1, 8'h77, 1'b0);
            chk("bp_acc_rdy", 32'(acc_in_ready), 32'd0);
            chk("bp_pkt_rdy", 32'(pkt_in_ready), 32'd0);
            chk("bp_slot", 32'(slot), 32'd2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        // Pop at count 2 with psum valid: psum must not be taken yet
        chk_out("bp6", 1'b1, 8'h88, 1'b0);
        chk("bp6_slot", 32'(slot), 32'd2);
        chk("bp6_pkt_rdy", 32'(pkt_in_ready), 32'd1);
        acc_in_valid = 1'b0;
        @(negedge clk);
        chk_out("bp7", 1'b1, 8'hD0, 1'b1);
        chk("bp7_fc_wrap", 32'(frame_count), 32'd0);
        pkt_in_valid = 1'b0;
        @(negedge clk);
        chk("bp8_valid", 32'(out_valid), 32'd0);

        // Mid-frame reset after one acc word
        out_ready = 1'b0;
        acc_in_valid = 1'b1; acc_in_data = 8'h99;
        @(negedge clk);
        chk_out("mr1", 1'b1, 8'h99, 1'b0);
        chk("mr1_slot", 32'(slot), 32'd1);
        rst = 1'b1; acc_in_valid = 1'b0;
        #1;
        chk("mr_rst_acc_rdy", 32'(acc_in_ready), 32'd0);
        @(negedge clk);
        chk_out("mr2", 1'b0, 8'h00, 1'b0);
        chk("mr2_slot", 32'(slot), 32'd0);
        chk("mr2_fc", 32'(frame_count), 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        acc_in_valid = 1'b1; acc_in_data = 8'hAA;
        pkt_in_valid = 1'b1; pkt_in_data = 8'hE0;
        @(negedge clk);
        chk_out("mr3", 1'b1, 8'hAA, 1'b0);
        acc_in_data = 8'hBB;
        @(negedge clk);
        chk_out("mr4", 1'b1, 8'hBB, 1'b0);
        @(negedge clk);
        chk_out("mr5", 1'b1, 8'hE0, 1'b1);
        chk("wrap_f0_fc", 32'(frame_count), 32'd1);

        // Four more back-to-back frames: frame_count 2,3,0,1
        for (int f = 1; f <= 4; f++) begin
            for (int s = 0; s < 3; s++) begin
                acc_in_data = 8'(f * 16 + s);
                pkt_in_data = 8'(8'hF0 + f);
                @(negedge clk);
                if (s < 2) begin
                    chk_out("wrap_acc", 1'b1, 8'(f * 16 + s), 1'b0);
                end else begin
                    chk_out("wrap_pkt", 1'b1, 8'(8'hF0 + f), 1'b1);
                    chk("wrap_fc", 32'(frame_count), 32'((f + 1) % 4));
                end
                chk("wrap_slot", 32'(slot), 32'((s + 1) % 3));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
